// File: rtl/jamma_joy_scanner.sv
// JAMMA two-player joystick scanner: time-multiplexes the shared JJOY bus
// through an external splitter, settles each select, samples once per player
// and debounces each player word before presenting it on JOY1/JOY2.
module jamma_joy_scanner #(
   parameter int unsigned SETTLE     = 4,
   parameter int unsigned DEBOUNCE_N = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [7:0] JJOY,
   input  logic [5:0] LOCAL_JOY,
   output logic       JSELECT,
   output logic [7:0] JOY1,
   output logic [7:0] JOY2,
   output logic       SCAN_DONE
);

   // Settle counter only ever holds 0..SETTLE-1.
   localparam int unsigned CntW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
   localparam logic [3:0] DbN = 4'(DEBOUNCE_N);

   typedef enum logic [1:0] {
      StP1Settle,
      StP1Sample,
      StP2Settle,
      StP2Sample
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] settle_q, settle_d;
   logic            jsel_q, jsel_d;
   logic            done_q, done_d;

   // Index 0 is player 1, index 1 is player 2.
   logic [1:0][7:0] cand_q, cand_d;
   logic [1:0][3:0] dcnt_q, dcnt_d;
   logic [1:0][7:0] joy_q, joy_d;
   logic [1:0][7:0] smp;
   logic [1:0]      smp_en;

   // Player 1 merges the on-board stick; upper two bits (buttons) pass through.
   assign smp[0]    = JJOY & {2'b11, LOCAL_JOY};
   assign smp[1]    = JJOY;
   assign smp_en[0] = (state_q == StP1Sample);
   assign smp_en[1] = (state_q == StP2Sample);

   // Scan FSM next state: settle for SETTLE cycles, sample for one, swap player.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      done_d   = 1'b0;
      if (ENABLE) begin
         unique case (state_q)
            StP1Settle: begin
               if (settle_q == SettleLast) begin
                  state_d  = StP1Sample;
                  settle_d = '0;
               end else begin
                  settle_d = settle_q + CntW'(1);
               end
            end
            StP1Sample: state_d = StP2Settle;
            StP2Settle: begin
               if (settle_q == SettleLast) begin
                  state_d  = StP2Sample;
                  settle_d = '0;
               end else begin
                  settle_d = settle_q + CntW'(1);
               end
            end
            StP2Sample: begin
               state_d = StP1Settle;
               done_d  = 1'b1;
            end
         endcase
      end
      jsel_d = (state_d == StP2Settle) || (state_d == StP2Sample);
   end

   // Per-player debounce: output follows candidate once it has been seen DEBOUNCE_N times.
   always_comb begin
      cand_d = cand_q;
      dcnt_d = dcnt_q;
      joy_d  = joy_q;
      for (int p = 0; p < 2; p++) begin
         if (ENABLE && smp_en[p]) begin
            if (smp[p] != cand_q[p]) begin
               cand_d[p] = smp[p];
               dcnt_d[p] = 4'd1;
            end else if (dcnt_q[p] < DbN) begin
               dcnt_d[p] = dcnt_q[p] + 4'd1;
            end
            if (dcnt_d[p] == DbN) begin
               joy_d[p] = cand_d[p];
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StP1Settle;
         settle_q <= '0;
         jsel_q   <= 1'b0;
         done_q   <= 1'b0;
         cand_q   <= '1;
         dcnt_q   <= {DbN, DbN};
         joy_q    <= '1;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         jsel_q   <= jsel_d;
         done_q   <= done_d;
         cand_q   <= cand_d;
         dcnt_q   <= dcnt_d;
         joy_q    <= joy_d;
      end
   end

   assign JSELECT   = jsel_q;
   assign JOY1      = joy_q[0];
   assign JOY2      = joy_q[1];
   // Gate so a pulse landing in a disabled cycle is dropped; the flop clears meanwhile.
   assign SCAN_DONE = done_q & ENABLE;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Directed bench for jamma_joy_scanner: default-parameter instance plus a
// SETTLE=1 / DEBOUNCE_N=1 instance, each behind its own modelled splitter.
module tb_jamma_joy_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en;
   logic [7:0] p1_bus;
   logic [7:0] p2_bus;
   logic [5:0] local_joy;

   logic       jsel, done;
   logic [7:0] joy1, joy2, jjoy;
   logic       f_jsel, f_done;
   logic [7:0] f_joy1, f_joy2, f_jjoy;

   // External splitter model.
   assign jjoy   = jsel ? p2_bus : p1_bus;
   assign f_jjoy = f_jsel ? p2_bus : p1_bus;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   jamma_joy_scanner u_dut (
      .CLK       (clk),
      .RESET     (rst),
      .ENABLE    (en),
      .JJOY      (jjoy),
      .LOCAL_JOY (local_joy),
      .JSELECT   (jsel),
      .JOY1      (joy1),
      .JOY2      (joy2),
      .SCAN_DONE (done)
   );

   jamma_joy_scanner #(
      .SETTLE     (1),
      .DEBOUNCE_N (1)
   ) u_dut_fast (
      .CLK       (clk),
      .RESET     (rst),
      .ENABLE    (en),
      .JJOY      (f_jjoy),
      .LOCAL_JOY (local_joy),
      .JSELECT   (f_jsel),
      .JOY1      (f_joy1),
      .JOY2      (f_joy2),
      .SCAN_DONE (f_done)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Cycle 0 is the first cycle with RESET low after a reset edge.
   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   logic [7:0] seq [7];
   logic       e_j, e_d;

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      p1_bus    = 8'hFF;
      p2_bus    = 8'hFF;
      local_joy = 6'h3F;
      seq = '{8'h7F, 8'h7F, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
      repeat (2) @(posedge clk);

      // Idle bus: select timing and scan pulse, both instances.
      do_reset();
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         e_j = (cyc % 10) >= 5;
         e_d = (cyc > 0) && (cyc % 10 == 0);
         check("idle_jsel", {7'd0, jsel}, {7'd0, e_j});
         check("idle_done", {7'd0, done}, {7'd0, e_d});
         check("idle_joy1", joy1, 8'hFF);
         check("idle_joy2", joy2, 8'hFF);
         e_j = (cyc % 4) >= 2;
         e_d = (cyc > 0) && (cyc % 4 == 0);
         check("fast_jsel", {7'd0, f_jsel}, {7'd0, e_j});
         check("fast_done", {7'd0, f_done}, {7'd0, e_d});
         next_cycle();
      end

      // Player-1 bus FE: appears after the third sample (cycle 25).
      p1_bus = 8'hFE;
      do_reset();
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         check("p1_joy1", joy1, (cyc >= 25) ? 8'hFE : 8'hFF);
         check("p1_joy2", joy2, 8'hFF);
         check("fast_p1_joy1", f_joy1, (cyc >= 2) ? 8'hFE : 8'hFF);
         check("fast_p1_joy2", f_joy2, 8'hFF);
         next_cycle();
      end

      // Local stick bit 1 pressed merges into player 1 only.
      p1_bus    = 8'hFF;
      local_joy = 6'h3D;
      do_reset();
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         check("loc_joy1", joy1, (cyc >= 25) ? 8'hFD : 8'hFF);
         check("loc_joy2", joy2, 8'hFF);
         check("fast_loc_joy1", f_joy1, (cyc >= 2) ? 8'hFD : 8'hFF);
         check("fast_loc_joy2", f_joy2, 8'hFF);
         next_cycle();
      end
      local_joy = 6'h3F;

      // Player-2 glitch: 7F,7F,FF,7F,7F,7F per scan -> JOY2 only moves at cycle 60.
      do_reset();
      for (int i = 0; i <= 62; i++) begin
         p2_bus = seq[cyc / 10];
         @(negedge clk);
         check("glitch_joy2", joy2, (cyc >= 60) ? 8'h7F : 8'hFF);
         check("glitch_joy1", joy1, 8'hFF);
         next_cycle();
      end
      p2_bus = 8'hFF;

      // ENABLE low cycles 7..13 during P2 settle: P2 sample slips from 9 to 16.
      do_reset();
      for (int i = 0; i <= 21; i++) begin
         en = !(cyc >= 7 && cyc <= 13);
         @(negedge clk);
         e_j = (cyc < 7) ? ((cyc % 10) >= 5) : (cyc <= 16);
         check("stall_jsel", {7'd0, jsel}, {7'd0, e_j});
         check("stall_done", {7'd0, done}, {7'd0, cyc == 17});
         next_cycle();
      end

      // ENABLE low in the pulse cycle: pulse dropped, P1 settle delayed by one.
      do_reset();
      for (int i = 0; i <= 21; i++) begin
         en = (cyc != 10);
         @(negedge clk);
         e_j = (cyc < 10) ? ((cyc % 10) >= 5) : (cyc >= 16 && cyc <= 20);
         check("supp_jsel", {7'd0, jsel}, {7'd0, e_j});
         check("supp_done", {7'd0, done}, {7'd0, cyc == 21});
         next_cycle();
      end
      en = 1'b1;

      // Reset mid-scan (with ENABLE low) after JOY2 has latched 7F.
      p2_bus = 8'h7F;
      do_reset();
      for (int i = 0; i <= 35; i++) begin
         @(negedge clk);
         check("pre_rst_joy2", joy2, (cyc >= 30) ? 8'h7F : 8'hFF);
         next_cycle();
      end
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      check("rst_cyc_done", {7'd0, done}, 8'h00);
      check("rst_cyc_jsel", {7'd0, jsel}, 8'h01);
      next_cycle();
      rst = 1'b0;
      en  = 1'b1;
      cyc = 0;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         e_j = (cyc % 10) >= 5;
         check("post_rst_jsel", {7'd0, jsel}, {7'd0, e_j});
         check("post_rst_done", {7'd0, done}, {7'd0, cyc == 10});
         check("post_rst_joy2", joy2, 8'hFF);
         check("post_rst_joy1", joy1, 8'hFF);
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/jamma_joy_scanner.md
JAMMA_JOY_SCANNER -- requirements
Module: jamma_joy_scanner

Interface
REQ-001 Parameter SETTLE, default 4: cycles JSELECT holds a value before JJOY is sampled; legal range 1..255.
REQ-002 Parameter DEBOUNCE_N, default 3: consecutive identical samples required before a player output updates; legal range 1..15.
REQ-003 CLK  input  1  pixel clock; single clock domain, all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 ENABLE  input  1  scan enable; low freezes all state.
REQ-006 JJOY  input  8  shared JAMMA joystick bus, active-low, driven by the external splitter per JSELECT.
REQ-007 LOCAL_JOY  input  6  on-board joystick, active-low, merged into player 1 only.
REQ-008 JSELECT  output  1  splitter select; 0 = player 1, 1 = player 2; registered.
REQ-009 JOY1  output  8  debounced player-1 word, active-low; registered.
REQ-010 JOY2  output  8  debounced player-2 word, active-low; registered.
REQ-011 SCAN_DONE  output  1  one-cycle pulse per completed two-player scan; registered.

Function
REQ-012 The FSM SHALL have four states: P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE.
REQ-013 In P1_SETTLE and P2_SETTLE, a settle counter SHALL count SETTLE cycles, then transition to the matching SAMPLE state and clear the counter.
REQ-014 Each SAMPLE state SHALL last exactly one cycle, then transition to the other player's SETTLE state (P1_SAMPLE->P2_SETTLE, P2_SAMPLE->P1_SETTLE).
REQ-015 JSELECT SHALL be 0 in P1_* states and 1 in P2_* states, so it changes on the cycle the FSM enters a SETTLE state.
REQ-016 Scan period SHALL be 2*(SETTLE+1) cycles; 10 cycles at the defaults.
REQ-017 P1_SAMPLE SHALL capture JJOY & {2'b11, LOCAL_JOY} as the player-1 sample.
REQ-018 P2_SAMPLE SHALL capture JJOY unmodified as the player-2 sample.
REQ-019 Each player SHALL keep a candidate register (8 bits) and a stable counter (4 bits).
REQ-020 On a sample that differs from the candidate: candidate <= sample and counter <= 1.
REQ-021 On a sample equal to the candidate: counter increments, saturating at DEBOUNCE_N.
REQ-022 The player output SHALL load the candidate on the cycle after the sample that makes the counter equal DEBOUNCE_N, and SHALL be unchanged otherwise.
REQ-023 With DEBOUNCE_N=1, the output SHALL follow every sample one cycle after P*_SAMPLE.
REQ-024 SCAN_DONE SHALL be 1 for exactly the one cycle after P2_SAMPLE, which is the first P1_SETTLE cycle; 0 otherwise.
REQ-025 While ENABLE=0, the FSM, settle counter, JSELECT, candidates, counters and outputs SHALL hold, and SCAN_DONE SHALL be 0.
REQ-026 When ENABLE returns high, operation SHALL resume from the held state and count.
REQ-027 If ENABLE falls in the cycle SCAN_DONE would assert, that pulse SHALL be suppressed, not deferred.
REQ-028 A glitch lasting fewer than DEBOUNCE_N consecutive samples SHALL never reach JOY1 or JOY2.
REQ-029 The settle counter SHALL be wide enough for SETTLE without wrap; no arithmetic SHALL overflow at the parameter maxima.

Reset
REQ-030 When RESET=1, at the next edge: FSM=P1_SETTLE, settle counter=0, JSELECT=0, JOY1=JOY2=8'hFF, SCAN_DONE=0, both candidates=8'hFF, both counters=DEBOUNCE_N.
REQ-031 RESET SHALL take priority over ENABLE.
REQ-032 RESET asserted mid-scan SHALL abandon the scan with no SCAN_DONE pulse.
REQ-033 The first P1_SAMPLE after reset release SHALL occur SETTLE cycles after release.

Verification
REQ-034 Defaults, ENABLE=1, JJOY=FF, LOCAL_JOY=3F, release reset at cycle 0 -> JSELECT rises at cycle 5, falls at 10; SCAN_DONE=1 at cycles 10, 20, 30; JOY1=JOY2=FF throughout.
REQ-035 JJOY=8'hFE held only while JSELECT=0, from cycle 0 -> JOY1 stays FF after samples 1 and 2, becomes FE the cycle after the 3rd P1_SAMPLE (cycle 25); JOY2 stays FF.
REQ-036 JJOY=FF, LOCAL_JOY=6'h3D constant -> JOY1 becomes FD after 3 scans; JOY2 stays FF.
REQ-037 Player-2 bus 7F for two scans, FF for one, then 7F -> JOY2 never changes from FF until three consecutive 7F samples.
REQ-038 ENABLE low for 7 cycles starting in P2_SETTLE with settle count=2 -> JSELECT stays 1 and no SCAN_DONE during the gap; P2_SAMPLE occurs exactly 7 cycles later than nominal.
REQ-039 RESET pulsed one cycle during P2_SETTLE with JOY2=7F -> next cycle JSELECT=0, JOY2=FF, no SCAN_DONE in that scan; first P1_SAMPLE at 4 cycles after release.
